mic_array_stim: RTL and testbench



---
 rtl/mic_array_stim.sv | 208 ++++++++++++++++++++
 tb/tb_mic_array_stim.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mic_array_stim.sv
`default_nettype none
// ============================================================================
//  Module      : mic_array_stim
//  Description : Multi-channel I2S microphone stimulus model. One source
//                sample stream (LFSR, or a frame ramp when the
//                MIC_STIM_RAMP_EN macro is defined) is presented on N_CH
//                serial data lines. Each line is delayed by its own whole
//                number of frames. The block slaves to an external bit
//                clock and word select.
//  Revision    : 1.0 - initial release
// ============================================================================
module mic_array_stim #(
    parameter int          N_CH      = 4,
    parameter int          SAMPLE_W  = 16,
    parameter int          MAX_DLY   = 15,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2024,
    parameter int          CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int          DLY_W     = $clog2(MAX_DLY + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sck_in,
    input  logic                ws_in,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DLY_W-1:0]    cfg_dly,
    output logic [N_CH-1:0]     mic_sd,
    output logic                frame_strobe,
    output logic [SAMPLE_W-1:0] sample_out
);

    localparam int                c_DEPTH   = MAX_DLY + 1;
    localparam int                c_BC_W    = $clog2(SAMPLE_W + 1);
    localparam logic [c_BC_W-1:0] c_BC_IDLE = c_BC_W'(SAMPLE_W);
    localparam logic [DLY_W-1:0]  c_DLY_MAX = DLY_W'(MAX_DLY);
    localparam logic [DLY_W:0]    c_DEPTH_W = (DLY_W + 1)'(c_DEPTH);

    // ------------------------------------------------------------------
    // Synchronisers and edge detectors for the externally timed I2S clocks
    // ------------------------------------------------------------------
    logic r_sck_s1, r_sck_s2, r_sck_s3, r_sck_rise;
    logic r_ws_s1,  r_ws_s2,  r_ws_s3,  r_ws_fall;

    // Two-flop synchronisers followed by registered edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_s1   <= 1'b0;
            r_sck_s2   <= 1'b0;
            r_sck_s3   <= 1'b0;
            r_sck_rise <= 1'b0;
            r_ws_s1    <= 1'b0;
            r_ws_s2    <= 1'b0;
            r_ws_s3    <= 1'b0;
            r_ws_fall  <= 1'b0;
        end else begin
            r_sck_s1   <= sck_in;
            r_sck_s2   <= r_sck_s1;
            r_sck_s3   <= r_sck_s2;
            r_sck_rise <= r_sck_s2 & ~r_sck_s3;
            r_ws_s1    <= ws_in;
            r_ws_s2    <= r_ws_s1;
            r_ws_s3    <= r_ws_s2;
            r_ws_fall  <= r_ws_s3 & ~r_ws_s2;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel delay configuration
    // ------------------------------------------------------------------
    logic [DLY_W-1:0] r_dly [N_CH];
    logic [DLY_W-1:0] w_cfg_dly;

    // Clamping is only needed when the delay field can encode values
    // above MAX_DLY.
    generate
        if (c_DEPTH == (2 ** DLY_W)) begin : g_noclamp
            assign w_cfg_dly = cfg_dly;
        end else begin : g_clamp
            assign w_cfg_dly = (cfg_dly > c_DLY_MAX) ? c_DLY_MAX : cfg_dly;
        end
    endgenerate

    // Delay register write; channel indices at or above N_CH match nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                r_dly[k] <= '0;
            end
        end else if (cfg_we) begin
            for (int k = 0; k < N_CH; k++) begin
                if (cfg_ch == CH_W'(k)) begin
                    r_dly[k] <= w_cfg_dly;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample source
    // ------------------------------------------------------------------
    logic                r_ws_low_unused;
    logic                w_load;
    logic [SAMPLE_W-1:0] w_src;

    assign w_load = en & r_ws_fall;
    assign r_ws_low_unused = 1'b0;

`ifdef MIC_STIM_RAMP_EN
    logic [SAMPLE_W-1:0] r_ramp;

    assign w_src = r_ramp + SAMPLE_W'(1);

    // Frame counter source: the first enabled frame carries value 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ramp <= '0;
        end else if (w_load) begin
            r_ramp <= w_src;
        end
    end
`else
    logic [31:0] r_lfsr;
    logic [31:0] w_lfsr_next;

    // Fibonacci LFSR, taps 32/22/2/1, shifting towards the MSB.
    assign w_lfsr_next = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
    assign w_src       = w_lfsr_next[SAMPLE_W-1:0];

    // LFSR advances exactly once per enabled frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_load) begin
            r_lfsr <= w_lfsr_next;
        end
    end
`endif

    // ------------------------------------------------------------------
    // History ring and read addressing
    // ------------------------------------------------------------------
    logic [SAMPLE_W-1:0] r_hist [c_DEPTH];
    logic [DLY_W-1:0]    r_wptr;
    logic [DLY_W-1:0]    w_rd_idx [N_CH];

    // Read index (wptr - dly) mod depth, computed with one guard bit.
    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            logic [DLY_W:0] w_diff;
            assign w_diff      = {1'b0, r_wptr} + c_DEPTH_W - {1'b0, r_dly[g]};
            assign w_rd_idx[g] = (w_diff >= c_DEPTH_W) ? DLY_W'(w_diff - c_DEPTH_W)
                                                       : DLY_W'(w_diff);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Frame load and serialiser
    // ------------------------------------------------------------------
    logic [SAMPLE_W-1:0] r_sh [N_CH];
    logic [c_BC_W-1:0]   r_bitcnt;

    // Frame load has priority over a coincident bit shift, so the MSB
    // always lands on the sck rise after the load (one-bit I2S lag).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < c_DEPTH; d++) begin
                r_hist[d] <= '0;
            end
            for (int k = 0; k < N_CH; k++) begin
                r_sh[k] <= '0;
            end
            r_wptr       <= '0;
            r_bitcnt     <= c_BC_IDLE;
            mic_sd       <= '0;
            frame_strobe <= 1'b0;
            sample_out   <= '0;
        end else begin
            frame_strobe <= 1'b0;
            if (!en) begin
                mic_sd   <= '0;
                r_bitcnt <= c_BC_IDLE;
            end else if (r_ws_fall) begin
                for (int k = 0; k < N_CH; k++) begin
                    r_sh[k] <= (r_dly[k] == '0) ? w_src : r_hist[w_rd_idx[k]];
                end
                r_hist[r_wptr] <= w_src;
                r_wptr         <= (r_wptr == c_DLY_MAX) ? '0 : r_wptr + DLY_W'(1);
                r_bitcnt       <= '0;
                sample_out     <= w_src;
                frame_strobe   <= 1'b1;
                mic_sd         <= '0;
            end else if (r_sck_rise) begin
                if (!r_ws_s3 && (r_bitcnt < c_BC_IDLE)) begin
                    for (int k = 0; k < N_CH; k++) begin
                        mic_sd[k] <= r_sh[k][SAMPLE_W-1];
                        r_sh[k]   <= r_sh[k] << 1;
                    end
                    r_bitcnt <= r_bitcnt + c_BC_W'(1);
                end else begin
                    mic_sd <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mic_array_stim.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mic_array_stim
//  Description : Self-checking bench for mic_array_stim. Drives I2S sck/ws
//                (32-bit slots), deserialises every channel and compares
//                against a frame-level source/delay model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mic_array_stim;

    localparam int N_CH     = 4;
    localparam int SAMPLE_W = 16;
    localparam int MAX_DLY  = 15;
    localparam int HALF     = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          sck_in;
    logic          ws_in;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [3:0]    cfg_dly;
    logic [3:0]    mic_sd;
    logic          frame_strobe;
    logic [15:0]   sample_out;

    always #5 clk = ~clk;

    mic_array_stim #(
        .N_CH     (N_CH),
        .SAMPLE_W (SAMPLE_W),
        .MAX_DLY  (MAX_DLY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sck_in       (sck_in),
        .ws_in        (ws_in),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_dly      (cfg_dly),
        .mic_sd       (mic_sd),
        .frame_strobe (frame_strobe),
        .sample_out   (sample_out)
    );

    int vectors     = 0;
    int miscompares = 0;
    int strobe_cnt  = 0;

    // Count clock cycles during which frame_strobe is high.
    always @(negedge clk) begin
        if (frame_strobe === 1'b1) strobe_cnt++;
    end

    // Reference model: frame index n, source history src_q[n], delays.
    int           n;
    logic [15:0]  src_q[$];
    int           dly_m[N_CH];
    logic [31:0]  lfsr_m;

    task automatic model_reset();
        n = 0;
        src_q.delete();
        src_q.push_back(16'h0);
        lfsr_m = 32'hACE1_2024;
        for (int k = 0; k < N_CH; k++) dly_m[k] = 0;
    endtask

    task automatic model_advance();
        n++;
`ifdef MIC_STIM_RAMP_EN
        src_q.push_back(16'(n));
`else
        lfsr_m = {lfsr_m[30:0], ^(lfsr_m & 32'h8020_0003)};
        src_q.push_back(lfsr_m[15:0]);
`endif
    endtask

    function automatic logic [15:0] exp_ch(int k);
        int d;
        d = dly_m[k];
        if (n > d) return src_q[n - d];
        return 16'h0;
    endfunction

    function automatic int clamp_dly(int d);
        return (d > MAX_DLY) ? MAX_DLY : d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int ch, input int d);
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_dly = 4'(d);
        @(negedge clk);
        cfg_we  = 1'b0;
        if (ch < N_CH) dly_m[ch] = clamp_dly(d);
    endtask

    // One I2S frame of 64 sck cycles (left slot while ws low). Optional
    // en drop or delay write at a given bit; cut < 64 stops early without
    // end-of-frame checks.
    task automatic run_frame(input string tag, input int cut, input int drop_at,
                             input int cfg_at, input int cfg_ch_v, input int cfg_dly_v);
        logic [15:0] exp_w[N_CH];
        logic [15:0] got[N_CH];
        logic [15:0] mask;
        logic [3:0]  extra;
        logic        loaded;
        int          s0;
        s0     = strobe_cnt;
        loaded = en;
        if (loaded) model_advance();
        for (int k = 0; k < N_CH; k++) begin
            exp_w[k] = loaded ? exp_ch(k) : 16'h0;
            got[k]   = 16'h0;
        end
        extra = 4'h0;
        for (int b = 0; b < cut; b++) begin
            sck_in = 1'b0;
            ws_in  = (b >= 32);
            if (b == drop_at) en = 1'b0;
            if (b == cfg_at) begin
                cfg_we  = 1'b1;
                cfg_ch  = 2'(cfg_ch_v);
                cfg_dly = 4'(cfg_dly_v);
            end
            #10;
            cfg_we = 1'b0;
            if (b == cfg_at && cfg_ch_v < N_CH) dly_m[cfg_ch_v] = clamp_dly(cfg_dly_v);
            if (b == drop_at) check({tag, " en-drop mic_sd"}, 32'(mic_sd), 32'h0);
            #(HALF - 10);
            sck_in = 1'b1;
            #HALF;
            if (b < 16) begin
                for (int k = 0; k < N_CH; k++) got[k][15 - b] = mic_sd[k];
            end else begin
                extra = extra | mic_sd;
            end
        end
        if (cut == 64) begin
            mask = (drop_at >= 0 && drop_at < 16) ? ~(16'hFFFF >> drop_at) : 16'hFFFF;
            for (int k = 0; k < N_CH; k++)
                check($sformatf("%s n=%0d ch%0d word", tag, n, k), 32'(got[k]), 32'(exp_w[k] & mask));
            check({tag, " tail bits"}, 32'(extra), 32'h0);
            check({tag, " strobe count"}, 32'(strobe_cnt - s0), loaded ? 32'd1 : 32'd0);
            check({tag, " sample_out"}, 32'(sample_out), 32'(src_q[n]));
        end
    endtask

    // Plain sck/ws toggling for bits [from, 64) without checks.
    task automatic finish_frame(input int from);
        for (int b = from; b < 64; b++) begin
            sck_in = 1'b0;
            ws_in  = (b >= 32);
            #HALF;
            sck_in = 1'b1;
            #HALF;
        end
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        sck_in  = 1'b0;
        ws_in   = 1'b1;
        cfg_we  = 1'b0;
        cfg_ch  = 2'd0;
        cfg_dly = 4'd0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("reset mic_sd", 32'(mic_sd), 32'h0);
        check("reset frame_strobe", 32'(frame_strobe), 32'h0);
        check("reset sample_out", 32'(sample_out), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Disabled: ten frames of silence
        for (int f = 0; f < 10; f++) run_frame("idle", 64, -1, -1, 0, 0);

        // Enabled, zero delays: all channels equal the source
        en = 1'b1;
        for (int f = 0; f < 2; f++) run_frame("nodly", 64, -1, -1, 0, 0);

        // Mixed delays {0,1,2,5}
        cfg_write(1, 1);
        cfg_write(2, 2);
        cfg_write(3, 5);
        for (int f = 0; f < 6; f++) run_frame("dly", 64, -1, -1, 0, 0);

        // Maximum delay on ch1
        cfg_write(1, 15);
        cfg_write(3, 0);
        for (int f = 0; f < 10; f++) run_frame("maxdly", 64, -1, -1, 0, 0);

        // Mid-frame delay change on ch2: 1 -> 3
        cfg_write(2, 1);
        run_frame("dlychg-pre", 64, -1, -1, 0, 0);
        run_frame("dlychg-mid", 64, -1, 20, 2, 3);
        run_frame("dlychg-post", 64, -1, -1, 0, 0);

        // en dropped at bit 7, off for two frames, then resumed
        run_frame("endrop", 64, 7, -1, 0, 0);
        for (int f = 0; f < 2; f++) run_frame("enoff", 64, -1, -1, 0, 0);
        en = 1'b1;
        for (int f = 0; f < 2; f++) run_frame("resume", 64, -1, -1, 0, 0);

        // Reset mid-frame
        run_frame("prerst", 12, -1, -1, 0, 0);
        rst = 1'b1;
        #2;
        check("midrst mic_sd", 32'(mic_sd), 32'h0);
        check("midrst frame_strobe", 32'(frame_strobe), 32'h0);
        check("midrst sample_out", 32'(sample_out), 32'h0);
        #18;
        rst = 1'b0;
        model_reset();
        finish_frame(12);
        for (int f = 0; f < 2; f++) run_frame("postrst", 64, -1, -1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
